// File: rtl/pipe_fwd_ctrl.sv
// pipe_fwd_ctrl
// Result-consumer side of the EXE stage. Carries EXE results through the
// MEM and WB slots, forwards the youngest matching result to the decode
// operands, and raises a one-cycle stall for load-use dependencies.
//
// Ports:
//   clock, resetn        : rising-edge clock, asynchronous active-low reset
//   drs, drt             : decode source register numbers
//   drsuse, drtuse       : decode instruction reads rs / rt
//   da_rf, db_rf         : register-file read values
//   ern, ealu            : EXE destination number and result
//   ewreg, em2reg        : EXE writes a register / EXE is a load
//   mmo                  : data-memory read value for the MEM-slot instruction
//   da, db               : forwarded decode operands
//   stall                : load-use stall request
//   mrn, malu, mwreg, mm2reg : MEM slot
//   wrn, wdata, wwreg    : WB slot (register-file write port)
//   stall_cnt            : saturating count of stall cycles
//
// There are no handshakes here: every slot advances on every clock edge,
// including stall cycles; the upstream bubble (ewreg=0) makes that safe.
module pipe_fwd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       drs,
  input  logic [4:0]       drt,
  input  logic             drsuse,
  input  logic             drtuse,
  input  logic [31:0]      da_rf,
  input  logic [31:0]      db_rf,
  input  logic [4:0]       ern,
  input  logic [31:0]      ealu,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [31:0]      mmo,
  output logic [31:0]      da,
  output logic [31:0]      db,
  output logic             stall,
  output logic [4:0]       mrn,
  output logic [31:0]      malu,
  output logic             mwreg,
  output logic             mm2reg,
  output logic [4:0]       wrn,
  output logic [31:0]      wdata,
  output logic             wwreg,
  output logic [CNT_W-1:0] stall_cnt
);

  // Value the MEM-slot instruction will eventually write back.
  logic [31:0] mem_val;
  assign mem_val = mm2reg ? mmo : malu;

  // Per-source match terms; destination 0 never forwards.
  logic rs_exe, rs_mem, rs_wb;
  logic rt_exe, rt_mem, rt_wb;

  always_comb begin
    rs_exe = ewreg & (ern != 5'd0) & (ern == drs);
    rs_mem = mwreg & (mrn != 5'd0) & (mrn == drs);
    rs_wb  = wwreg & (wrn != 5'd0) & (wrn == drs);
    rt_exe = ewreg & (ern != 5'd0) & (ern == drt);
    rt_mem = mwreg & (mrn != 5'd0) & (mrn == drt);
    rt_wb  = wwreg & (wrn != 5'd0) & (wrn == drt);
  end

  // Youngest producer wins. A load in EXE does not forward (its data is not
  // available yet) and also blocks older MEM/WB matches, since the value the
  // reader needs is the load's; that cycle is a stall so da/db are unused.
  always_comb begin
    da = da_rf;
    if (rs_exe) begin
      if (!em2reg) da = ealu;
    end else if (rs_mem) begin
      da = mem_val;
    end else if (rs_wb) begin
      da = wdata;
    end
  end

  always_comb begin
    db = db_rf;
    if (rt_exe) begin
      if (!em2reg) db = ealu;
    end else if (rt_mem) begin
      db = mem_val;
    end else if (rt_wb) begin
      db = wdata;
    end
  end

  // Load-use: only sources actually read by the decode instruction count.
  assign stall = ewreg & em2reg & (ern != 5'd0) &
                 ((drsuse & (ern == drs)) | (drtuse & (ern == drt)));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mrn       <= '0;
      malu      <= '0;
      mwreg     <= 1'b0;
      mm2reg    <= 1'b0;
      wrn       <= '0;
      wdata     <= '0;
      wwreg     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      mrn    <= ern;
      malu   <= ealu;
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      wrn    <= mrn;
      wdata  <= mem_val;
      wwreg  <= mwreg;
      // Saturate at all-ones rather than wrapping.
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipe_fwd_ctrl.md
# pipe_fwd_ctrl

Result-consumer side of the EXE stage. Registers the EXE results (destination number, ALU/link value, write enables) through the MEM and WB slots. Resolves decode-stage operand hazards by forwarding from EXE, MEM and WB. Raises a one-cycle-per-hazard stall for load-use dependencies. Sits between the EXE stage outputs (`ern`, `ealu`) and the decode-stage operand muxes. It also keeps a saturating stall counter for performance debug.

## Interface
Parameters:
- `CNT_W`, 16, width of the stall counter

Ports:
- `clock` in 1: single clock, rising edge
- `resetn` in 1: asynchronous, active-low reset
- `drs`, `drt` in 5: decode-stage source register numbers
- `drsuse`, `drtuse` in 1: the decode instruction actually reads rs / rt
- `da_rf`, `db_rf` in 32: register-file read values for rs / rt
- `ern` in 5: EXE destination register number (already 31 for jal)
- `ealu` in 32: EXE result (ALU or PC+8)
- `ewreg`, `em2reg` in 1: EXE writes a register / EXE is a load
- `mmo` in 32: data-memory read value for the MEM-slot instruction
- `da`, `db` out 32: forwarded operands to decode
- `stall` out 1: freeze PC and IF/ID, insert bubble into ID/EXE
- `mrn` out 5, `malu` out 32, `mwreg` out 1, `mm2reg` out 1: MEM-slot registers
- `wrn` out 5, `wdata` out 32, `wwreg` out 1: WB-slot registers, drive the register-file write port
- `stall_cnt` out CNT_W: count of stall cycles

## Operation
- On each rising edge, MEM slot ← {`ern`, `ealu`, `ewreg`, `em2reg`}.
- On each rising edge, WB slot ← {`mrn`, `mm2reg ? mmo : malu`, `mwreg`}.
- The slots advance unconditionally, including during `stall`. The upstream bubble (`ewreg=0`) keeps the EXE slot harmless.
- Forward `da` by per-source priority; `db` uses the identical rule with `drt`/`db_rf`. A match means the destination equals `drs`, the write-enable is set, and the destination ≠ 0. Priority:
  - EXE match and `em2reg=0` → `ealu`
  - else MEM match → `mm2reg ? mmo : malu`
  - else WB match → `wdata`
  - else → `da_rf`
- Register 0 is never forwarded; `da`/`db` for source 0 equal the RF value.
- `stall` = `ewreg & em2reg & (ern≠0) & ((drsuse & ern==drs) | (drtuse & ern==drt))`.
  - During a stall, `da`/`db` are don't-care.
  - The next cycle the load is in MEM and resolves via the MEM path.
- `stall_cnt` increments on every edge where `stall=1`. It saturates at all-ones and does not wrap.
- Simultaneous EXE and MEM matches on the same register: EXE wins (youngest), unless EXE is a load. A load in EXE stalls, and the MEM value is not used that cycle.

## Timing
- `da`, `db`, `stall`: combinational from inputs and slot registers, same cycle.
- EXE result visible on `mrn`/`malu` 1 cycle after presentation, and on `wrn`/`wdata` 2 cycles after.
- Load-use stall lasts exactly 1 cycle per dependent instruction.
- Reset (`resetn=0`, asynchronous, any time including mid-stall): all slot registers 0, `mwreg=wwreg=mm2reg=0`, `stall_cnt=0`.
  - `stall` and `da`/`db` then follow inputs only (RF path or EXE path).
- First edge after release samples normally.

## Test plan
- Reset mid-run: assert `resetn=0` while `mwreg=1` and `stall_cnt=5` → immediately `wwreg=mwreg=0` and `stall_cnt=0`; on release, `da=da_rf`.
- EXE forward: `ern=3`, `ewreg=1`, `em2reg=0`, `ealu=0x1234`, `drs=3`, `drsuse=1` → `da=0x1234`, `stall=0`; next cycle `malu=0x1234`, `mrn=3`.
- Load-use: `ern=5`, `ewreg=1`, `em2reg=1`, `drt=5`, `drtuse=1` → `stall=1` for one cycle. Next cycle with `mmo=0xCAFE`, `ern=0`, `ewreg=0` → `db=0xCAFE`, `stall=0`, `stall_cnt=1`.
- Priority: EXE writes r7=0xA while MEM holds r7=0xB and WB holds r7=0xC, `drs=7` → `da=0xA`. Then drop `ewreg` → `da=0xB`. Then clear `mwreg` → `da=0xC`.
- r0 guard: `ern=0`, `ewreg=1`, `em2reg=1`, `ealu=0xFFFF`, `drs=0`, `da_rf=0` → `da=0`, `stall=0`.
- Saturation: with `CNT_W=4`, hold the load-use condition for 20 cycles → `stall_cnt` stops at 15.
